// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
// Round-robin arbiter that shares one memory read/write port among
// NUM_CONSUMERS requesters. One transaction is in flight at a time. Each one
// goes through select, memory ready and release. Reads win over writes from
// the same consumer.
//
// Ports
//   clk, reset              : clock and synchronous active-high reset
//   consumer_read_*         : per-consumer read request/address in, ready/data out
//   consumer_write_*        : per-consumer write request/address/data in, ready out
//   mem_read_*, mem_write_* : shared memory port (valid/address/data out, ready/data in)
//   busy                    : high whenever the FSM is not idle
//   grant_id                : consumer currently (or last) served
//   grant_count             : completed transactions, saturating at 0xFFFF
// Per-consumer buses are packed with consumer k at [k*W +: W].
module mem_rr_arbiter #(
  parameter int NUM_CONSUMERS = 8,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  localparam int ID_BITS      = $clog2(NUM_CONSUMERS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready,
  output logic                               busy,
  output logic [ID_BITS-1:0]                 grant_id,
  output logic [15:0]                        grant_count
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_READ_WAIT   = 3'd1;
  localparam logic [2:0] S_WRITE_WAIT  = 3'd2;
  localparam logic [2:0] S_READ_RELAY  = 3'd3;
  localparam logic [2:0] S_WRITE_RELAY = 3'd4;

  logic [2:0]                         state_q, state_d;
  logic [ID_BITS-1:0]                 ptr_q, ptr_d;
  logic [ID_BITS-1:0]                 grant_id_q, grant_id_d;
  logic [15:0]                        grant_count_q, grant_count_d;
  logic                               busy_q, busy_d;
  logic                               mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]               mem_read_address_q, mem_read_address_d;
  logic                               mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]               mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]               mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_q, consumer_read_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_q, consumer_write_ready_d;

  logic                               found;
  logic [ID_BITS-1:0]                 idx;

  // Next-state logic. Every register holds its value unless the current
  // state says otherwise. This is what keeps the memory address and data
  // stable while a valid is up: they are only loaded at selection time.
  always_comb begin
    state_d                = state_q;
    ptr_d                  = ptr_q;
    grant_id_d             = grant_id_q;
    grant_count_d          = grant_count_q;
    mem_read_valid_d       = mem_read_valid_q;
    mem_read_address_d     = mem_read_address_q;
    mem_write_valid_d      = mem_write_valid_q;
    mem_write_address_d    = mem_write_address_q;
    mem_write_data_d       = mem_write_data_q;
    consumer_read_ready_d  = consumer_read_ready_q;
    consumer_read_data_d   = consumer_read_data_q;
    consumer_write_ready_d = consumer_write_ready_q;
    found                  = 1'b0;
    idx                    = '0;

    case (state_q)
      S_IDLE: begin
        // Scan from ptr upward. The index wraps naturally because
        // NUM_CONSUMERS is a power of two.
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
          idx = ptr_q + ID_BITS'(i);
          if (!found && (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
            found      = 1'b1;
            grant_id_d = idx;
            if (consumer_read_valid[idx]) begin
              mem_read_valid_d   = 1'b1;
              mem_read_address_d = consumer_read_address[idx*ADDR_BITS +: ADDR_BITS];
              state_d            = S_READ_WAIT;
            end else begin
              mem_write_valid_d   = 1'b1;
              mem_write_address_d = consumer_write_address[idx*ADDR_BITS +: ADDR_BITS];
              mem_write_data_d    = consumer_write_data[idx*DATA_BITS +: DATA_BITS];
              state_d             = S_WRITE_WAIT;
            end
          end
        end
      end
      S_READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_d = 1'b0;
          consumer_read_data_d[grant_id_q*DATA_BITS +: DATA_BITS] = mem_read_data;
          consumer_read_ready_d[grant_id_q] = 1'b1;
          state_d = S_READ_RELAY;
        end
      end
      S_WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_d = 1'b0;
          consumer_write_ready_d[grant_id_q] = 1'b1;
          state_d = S_WRITE_RELAY;
        end
      end
      S_READ_RELAY: begin
        // Hold ready until the consumer drops its request. This is the
        // release edge, so the pointer moves past the served consumer here.
        if (!consumer_read_valid[grant_id_q]) begin
          consumer_read_ready_d[grant_id_q] = 1'b0;
          ptr_d   = grant_id_q + ID_BITS'(1);
          state_d = S_IDLE;
          if (grant_count_q != 16'hFFFF) grant_count_d = grant_count_q + 16'd1;
        end
      end
      S_WRITE_RELAY: begin
        if (!consumer_write_valid[grant_id_q]) begin
          consumer_write_ready_d[grant_id_q] = 1'b0;
          ptr_d   = grant_id_q + ID_BITS'(1);
          state_d = S_IDLE;
          if (grant_count_q != 16'hFFFF) grant_count_d = grant_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers. Reset clears everything, which also
  // abandons any memory transaction that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                <= S_IDLE;
      ptr_q                  <= '0;
      grant_id_q             <= '0;
      grant_count_q          <= '0;
      busy_q                 <= 1'b0;
      mem_read_valid_q       <= 1'b0;
      mem_read_address_q     <= '0;
      mem_write_valid_q      <= 1'b0;
      mem_write_address_q    <= '0;
      mem_write_data_q       <= '0;
      consumer_read_ready_q  <= '0;
      consumer_read_data_q   <= '0;
      consumer_write_ready_q <= '0;
    end else begin
      state_q                <= state_d;
      ptr_q                  <= ptr_d;
      grant_id_q             <= grant_id_d;
      grant_count_q          <= grant_count_d;
      busy_q                 <= busy_d;
      mem_read_valid_q       <= mem_read_valid_d;
      mem_read_address_q     <= mem_read_address_d;
      mem_write_valid_q      <= mem_write_valid_d;
      mem_write_address_q    <= mem_write_address_d;
      mem_write_data_q       <= mem_write_data_d;
      consumer_read_ready_q  <= consumer_read_ready_d;
      consumer_read_data_q   <= consumer_read_data_d;
      consumer_write_ready_q <= consumer_write_ready_d;
    end
  end

  assign consumer_read_ready  = consumer_read_ready_q;
  assign consumer_read_data   = consumer_read_data_q;
  assign consumer_write_ready = consumer_write_ready_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;
  assign busy                 = busy_q;
  assign grant_id             = grant_id_q;
  assign grant_count          = grant_count_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
// Directed testbench for mem_rr_arbiter with the default 8 consumers and
// 8-bit address and data. The bench drives inputs and samples outputs 1 time
// unit after each rising edge. Expected values are written out by hand.
module tb_mem_rr_arbiter;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    consumer_read_valid = '0;
  logic [N*8-1:0]  consumer_read_address = '0;
  logic [N-1:0]    consumer_read_ready;
  logic [N*8-1:0]  consumer_read_data;
  logic [N-1:0]    consumer_write_valid = '0;
  logic [N*8-1:0]  consumer_write_address = '0;
  logic [N*8-1:0]  consumer_write_data = '0;
  logic [N-1:0]    consumer_write_ready;
  logic            mem_read_valid;
  logic [7:0]      mem_read_address;
  logic            mem_read_ready = 1'b0;
  logic [7:0]      mem_read_data = '0;
  logic            mem_write_valid;
  logic [7:0]      mem_write_address;
  logic [7:0]      mem_write_data;
  logic            mem_write_ready = 1'b0;
  logic            busy;
  logic [2:0]      grant_id;
  logic [15:0]     grant_count;

  int check_count = 0;
  int error_count = 0;

  mem_rr_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .busy                   (busy),
    .grant_id               (grant_id),
    .grant_count            (grant_count)
  );

  // Free-running clock with a period of 10 time units.
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are stable for sampling
  // and inputs can be changed safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value and report any
  // difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Raise the read request of consumer k with the given address.
  task automatic applyStimulus(input int k, input logic [7:0] addr);
    consumer_read_valid[k] = 1'b1;
    consumer_read_address[k*8 +: 8] = addr;
  endtask

  // Run one full read for consumer k, whose request must already be raised.
  // The steps are: select edge, then `stall` wait cycles, then the memory
  // ready edge, one extra relay cycle, and finally the release edge. During
  // the stall cycles the bench scrambles the consumer address and pulses the
  // non-matching write ready. Both of these must be ignored.
  task automatic readTransaction(input int k, input logic [7:0] addr,
                                 input logic [7:0] data, input int stall,
                                 input logic [15:0] exp_count);
    tick();
    checkOutput("sel_grant_id", 32'(grant_id), 32'(k));
    checkOutput("sel_mem_read_valid", 32'(mem_read_valid), 32'd1);
    checkOutput("sel_mem_read_address", 32'(mem_read_address), 32'(addr));
    checkOutput("sel_mem_write_valid", 32'(mem_write_valid), 32'd0);
    checkOutput("sel_busy", 32'(busy), 32'd1);
    for (int s = 0; s < stall; s++) begin
      consumer_read_address[k*8 +: 8] = ~addr;
      mem_write_ready = 1'b1;
      tick();
      checkOutput("stall_mem_read_valid", 32'(mem_read_valid), 32'd1);
      checkOutput("stall_mem_read_address", 32'(mem_read_address), 32'(addr));
      checkOutput("stall_busy", 32'(busy), 32'd1);
      checkOutput("stall_write_ready", 32'(consumer_write_ready), 32'd0);
    end
    mem_write_ready = 1'b0;
    consumer_read_address[k*8 +: 8] = addr;
    mem_read_ready = 1'b1;
    mem_read_data = data;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data = 8'h00;
    checkOutput("resp_mem_read_valid", 32'(mem_read_valid), 32'd0);
    checkOutput("resp_read_ready", 32'(consumer_read_ready), 32'd1 << k);
    checkOutput("resp_read_data", 32'(consumer_read_data[k*8 +: 8]), 32'(data));
    tick();
    checkOutput("relay_read_ready", 32'(consumer_read_ready), 32'd1 << k);
    consumer_read_valid[k] = 1'b0;
    tick();
    checkOutput("rel_read_ready", 32'(consumer_read_ready), 32'd0);
    checkOutput("rel_grant_count", 32'(grant_count), 32'(exp_count));
    checkOutput("rel_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state: every output is cleared.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_grant_count", 32'(grant_count), 32'd0);
    checkOutput("rst_mem_read_valid", 32'(mem_read_valid), 32'd0);
    checkOutput("rst_mem_write_valid", 32'(mem_write_valid), 32'd0);
    checkOutput("rst_mem_read_address", 32'(mem_read_address), 32'd0);
    checkOutput("rst_read_ready", 32'(consumer_read_ready), 32'd0);
    checkOutput("rst_write_ready", 32'(consumer_write_ready), 32'd0);

    // Idle with no requests: memory ready strobes arrive outside any wait
    // state and must have no effect.
    mem_read_ready = 1'b1;
    mem_write_ready = 1'b1;
    tick();
    tick();
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_read_ready", 32'(consumer_read_ready), 32'd0);
    checkOutput("idle_write_ready", 32'(consumer_write_ready), 32'd0);
    checkOutput("idle_mem_read_valid", 32'(mem_read_valid), 32'd0);

    // Contention: consumers 0, 2 and 5 request from reset. Expected grant
    // order is 0, 2, 5, then wrap to 0.
    applyStimulus(0, 8'h01);
    applyStimulus(2, 8'h02);
    applyStimulus(5, 8'h05);
    readTransaction(0, 8'h01, 8'hC0, 0, 16'd1);
    applyStimulus(0, 8'h01);
    readTransaction(2, 8'h02, 8'hC2, 0, 16'd2);
    applyStimulus(2, 8'h02);
    readTransaction(5, 8'h05, 8'hC5, 0, 16'd3);
    applyStimulus(5, 8'h05);
    readTransaction(0, 8'h01, 8'hD0, 0, 16'd4);
    consumer_read_valid = '0;

    // Single read: consumer 3 reads address 0x42, and memory answers with
    // 0xA5 two cycles after the select edge. ptr is 1, so 3 is found first.
    applyStimulus(3, 8'h42);
    readTransaction(3, 8'h42, 8'hA5, 1, 16'd5);

    // Read/write priority on consumer 1: the read goes first.
    applyStimulus(1, 8'h10);
    consumer_write_valid[1] = 1'b1;
    consumer_write_address[1*8 +: 8] = 8'h20;
    consumer_write_data[1*8 +: 8] = 8'h77;
    readTransaction(1, 8'h10, 8'h3C, 0, 16'd6);
    // The write is still pending, so the next scan (from ptr 2) wraps to 1.
    tick();
    checkOutput("wr_mem_write_valid", 32'(mem_write_valid), 32'd1);
    checkOutput("wr_mem_write_address", 32'(mem_write_address), 32'h20);
    checkOutput("wr_mem_write_data", 32'(mem_write_data), 32'h77);
    checkOutput("wr_grant_id", 32'(grant_id), 32'd1);
    checkOutput("wr_mem_read_valid", 32'(mem_read_valid), 32'd0);
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    checkOutput("wr_resp_valid", 32'(mem_write_valid), 32'd0);
    checkOutput("wr_resp_ready", 32'(consumer_write_ready), 32'h02);
    checkOutput("wr_resp_read_ready", 32'(consumer_read_ready), 32'd0);
    consumer_write_valid[1] = 1'b0;
    tick();
    checkOutput("wr_rel_ready", 32'(consumer_write_ready), 32'd0);
    checkOutput("wr_rel_grant_count", 32'(grant_count), 32'd7);
    checkOutput("wr_rel_busy", 32'(busy), 32'd0);
    // Each read-data slice keeps the value from its last read.
    checkOutput("data_slice3_kept", 32'(consumer_read_data[3*8 +: 8]), 32'hA5);
    checkOutput("data_slice1_kept", 32'(consumer_read_data[1*8 +: 8]), 32'h3C);
    checkOutput("data_slice0_kept", 32'(consumer_read_data[0*8 +: 8]), 32'hD0);

    // Stall: memory holds read ready low for 50 cycles.
    applyStimulus(6, 8'h9E);
    readTransaction(6, 8'h9E, 8'h61, 50, 16'd8);

    // Reset during READ_WAIT, with memory ready arriving on the same edge.
    // Reset must win, and no ready pulse may appear.
    applyStimulus(4, 8'h33);
    tick();
    checkOutput("mid_mem_read_valid", 32'(mem_read_valid), 32'd1);
    reset = 1'b1;
    mem_read_ready = 1'b1;
    mem_read_data = 8'hEE;
    tick();
    reset = 1'b0;
    mem_read_ready = 1'b0;
    checkOutput("mid_rst_mem_read_valid", 32'(mem_read_valid), 32'd0);
    checkOutput("mid_rst_mem_read_address", 32'(mem_read_address), 32'd0);
    checkOutput("mid_rst_read_ready", 32'(consumer_read_ready), 32'd0);
    checkOutput("mid_rst_read_data", 32'(consumer_read_data[31:0]), 32'd0);
    checkOutput("mid_rst_grant_count", 32'(grant_count), 32'd0);
    checkOutput("mid_rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    // After reset the still-raised request from consumer 4 is served.
    readTransaction(4, 8'h33, 8'h5C, 0, 16'd1);

    // Saturation: preload the count to 0xFFFE, then run two transactions.
    force dut.grant_count_q = 16'hFFFE;
    tick();
    release dut.grant_count_q;
    checkOutput("sat_preload", 32'(grant_count), 32'hFFFE);
    applyStimulus(7, 8'h77);
    readTransaction(7, 8'h77, 8'h11, 0, 16'hFFFF);
    applyStimulus(2, 8'h22);
    readTransaction(2, 8'h22, 8'h12, 0, 16'hFFFF);
    tick();
    checkOutput("sat_hold", 32'(grant_count), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameters SHALL be as follows.
  NUM_CONSUMERS, 8, number of requesters; power of two, 2..8.
  ADDR_BITS, 8, address width.
  DATA_BITS, 8, data width.
REQ-002 Ports SHALL be as follows; per-consumer buses are packed with consumer k at [k*W +: W].
  clk  in  1  clock; all state changes on the rising edge.
  reset  in  1  synchronous, active-high reset.
  consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
  consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  read addresses.
  consumer_read_ready  out  NUM_CONSUMERS  per-consumer read response.
  consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  read data.
  consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
  consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  write addresses.
  consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  write data.
  consumer_write_ready  out  NUM_CONSUMERS  per-consumer write acknowledge.
  mem_read_valid  out  1  shared memory port, read request.
  mem_read_address  out  ADDR_BITS  read address.
  mem_read_ready  in  1  read data valid.
  mem_read_data  in  DATA_BITS  read data.
  mem_write_valid  out  1  write request.
  mem_write_address  out  ADDR_BITS  write address.
  mem_write_data  out  DATA_BITS  write data.
  mem_write_ready  in  1  write acknowledge.
  busy  out  1  high whenever the state is not IDLE.
  grant_id  out  log2(NUM_CONSUMERS)  consumer currently being served.
  grant_count  out  16  number of completed transactions; saturates at 0xFFFF.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have five states:
  - IDLE
  - READ_WAIT
  - WRITE_WAIT
  - READ_RELAY
  - WRITE_RELAY
REQ-005 In IDLE, the block SHALL scan consumers in the order ptr, ptr+1, ... modulo NUM_CONSUMERS and select the first consumer k with read_valid[k] or write_valid[k] set.
REQ-006 If both read_valid[k] and write_valid[k] are set, the read SHALL be served first; the write remains pending.
REQ-007 On a read selection at edge E0, the following SHALL take effect after E0:
  - mem_read_valid=1
  - mem_read_address = address of k
  - grant_id=k
  - state READ_WAIT
REQ-008 On a write selection at edge E0, the following SHALL take effect after E0:
  - mem_write_valid=1
  - address and data of k driven on the memory port
  - grant_id=k
  - state WRITE_WAIT
REQ-009 Memory address and data outputs SHALL be held stable while mem_*_valid is high; consumer input changes during this time SHALL be ignored.
REQ-010 READ_WAIT: when mem_read_ready=1 is sampled, the following SHALL take effect on the next edge:
  - mem_read_valid=0
  - consumer_read_data slice k = mem_read_data
  - consumer_read_ready[k]=1
  - state READ_RELAY
REQ-011 WRITE_WAIT: when mem_write_ready=1 is sampled, the following SHALL take effect on the next edge:
  - mem_write_valid=0
  - consumer_write_ready[k]=1
  - state WRITE_RELAY
REQ-012 READ_RELAY / WRITE_RELAY: the matching ready[k] SHALL stay high until the matching valid[k] is sampled low. On that edge:
  - ready[k]=0
  - ptr = (k+1) mod NUM_CONSUMERS
  - grant_count increments, saturating at 0xFFFF
  - state IDLE
REQ-013 consumer_read_data slice k SHALL retain its value until the next read served for k; all other slices SHALL be unaffected.
REQ-014 At most one consumer ready bit SHALL be high at any time.
REQ-015 Minimum transaction length SHALL be 3 edges (select, memory ready, release); the next grant SHALL occur no earlier than the edge after the release.
REQ-016 With no request pending in IDLE, all valid and ready outputs SHALL stay 0 and ptr SHALL be unchanged.
REQ-017 A memory ready asserted while the FSM is not in the matching WAIT state SHALL be ignored.
REQ-018 Round-robin SHALL guarantee that any continuously requesting consumer is granted within NUM_CONSUMERS transactions.

Reset
REQ-019 reset=1 SHALL force the following on the next edge, regardless of state:
  - state=IDLE, ptr=0
  - all valid and ready outputs 0
  - all address and data outputs 0
  - grant_id=0, grant_count=0, busy=0
REQ-020 Reset mid-transaction SHALL abandon the memory transaction; no ready pulse SHALL be produced for it.

Verification
REQ-021 Read: consumer 3 reads addr 0x42; memory returns 0xA5 two cycles later -> mem_read_address=0x42, then consumer_read_ready[3]=1 and slice 3=0xA5; after valid drops, ready=0 and grant_count=1.
REQ-022 Contention: consumers 0, 2 and 5 all request reads continuously from reset -> grant order 0, 2, 5, 0; no consumer granted twice before the others.
REQ-023 Read/write priority: consumer 1 requests a read (0x10) and a write (0x20, data 0x77) simultaneously -> read served first, then write to 0x20 with 0x77 after the next scan.
REQ-024 Reset mid-operation: reset asserted during READ_WAIT -> next edge all outputs 0, no consumer_read_ready pulse; a fresh request after reset is served normally.
REQ-025 Saturation: grant_count forced to 0xFFFE, then two transactions -> grant_count 0xFFFF and held.
REQ-026 Stall: mem_read_ready held low for 50 cycles -> mem_read_valid and address held stable throughout; busy=1 throughout.
